// File: rtl/subtrator_defs.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package subtrator_defs;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] CALCULA = 2'd1;
    localparam logic [1:0] FIM     = 2'd2;

    // A single-bit operand still needs one counter bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subtrator1Bit.sv
// Combinational 1-bit full subtractor: D = A - B - Bin, with borrow out.
module subtrator1Bit (
    output logic D,
    output logic Bout,
    input  logic A,
    input  logic B,
    input  logic Bin
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: D = A - B, one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
module subtrator_serial
    import subtrator_defs::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state
);

    localparam int CW = cnt_width(N);

    logic [1:0]    state_q;
    logic [N-1:0]  reg_a;
    logic [N-1:0]  reg_b;
    logic [N-1:0]  res;
    logic [N-1:0]  res_next;
    logic [CW-1:0] cnt;
    logic          bin;
    logic          d_bit;
    logic          b_next;

    subtrator1Bit u_cell (
        .D    (d_bit),
        .Bout (b_next),
        .A    (reg_a[0]),
        .B    (reg_b[0]),
        .Bin  (bin)
    );

    // Result bits enter at the MSB so after N shifts bit 0 sits at res[0].
    assign res_next = (res >> 1) | (N'(d_bit) << (N - 1));
    assign state    = state_q;

    // Handshake: start is sampled only in OCIOSO or FIM; an accepted start
    // captures A/B on that edge. done pulses for the single FIM cycle, when
    // D/Bout take the new result; D/Bout then hold until the next FIM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OCIOSO;
            reg_a   <= '0;
            reg_b   <= '0;
            res     <= '0;
            cnt     <= '0;
            bin     <= 1'b0;
            D       <= '0;
            Bout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                OCIOSO, FIM: begin
                    done <= 1'b0;
                    if (start) begin
                        reg_a   <= A;
                        reg_b   <= B;
                        bin     <= 1'b0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state_q <= CALCULA;
                    end else begin
                        state_q <= OCIOSO;
                    end
                end
                CALCULA: begin
                    reg_a <= reg_a >> 1;
                    reg_b <= reg_b >> 1;
                    res   <= res_next;
                    bin   <= b_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        D       <= res_next;
                        Bout    <= b_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= FIM;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtrator_serial.sv
// Scoreboard bench for subtrator_serial at N = 8, 1 and 16: drivers push
// {Bout, D} and the expected done cycle; per-instance monitors pop on done.
module tb_subtrator_serial;
    import subtrator_defs::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start8 = 1'b0, start1 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, d8;
    logic [0:0]  a1 = '0, b1 = '0, d1;
    logic [15:0] a16 = '0, b16 = '0, d16;
    logic        bout8, busy8, done8, bout1, busy1, done1, bout16, busy16, done16;
    logic [1:0]  st8, st1, st16;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [8:0]  q8[$];
    int          c8[$];
    logic [1:0]  q1[$];
    int          c1[$];
    logic [16:0] q16[$];
    int          c16[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    subtrator_serial #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .D(d8), .Bout(bout8), .busy(busy8), .done(done8), .state(st8)
    );
    subtrator_serial #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .D(d1), .Bout(bout1), .busy(busy1), .done(done1), .state(st1)
    );
    subtrator_serial #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16),
        .D(d16), .Bout(bout16), .busy(busy16), .done(done16), .state(st16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) check("n8_unexpected_done", 32'(done8), 32'd0);
            else begin
                check("n8_result", {bout8, d8}, q8.pop_front());
                check("n8_latency", cyc, c8.pop_front());
            end
        end
        if (!rst && done1) begin
            if (q1.size() == 0) check("n1_unexpected_done", 32'(done1), 32'd0);
            else begin
                check("n1_result", {bout1, d1}, q1.pop_front());
                check("n1_latency", cyc, c1.pop_front());
            end
        end
        if (!rst && done16) begin
            if (q16.size() == 0) check("n16_unexpected_done", 32'(done16), 32'd0);
            else begin
                check("n16_result", {bout16, d16}, q16.pop_front());
                check("n16_latency", cyc, c16.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    // Done is expected N edges after the start edge (cyc + 1).
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        q8.push_back(exp);
        c8.push_back(cyc + 1 + 8);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go1(input logic a, input logic b, input logic [1:0] exp);
        @(negedge clk);
        a1 = a; b1 = b; start1 = 1'b1;
        q1.push_back(exp);
        c1.push_back(cyc + 1 + 1);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic go16(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        a16 = a; b16 = b; start16 = 1'b1;
        q16.push_back({(a < b), 16'(a - b)});
        c16.push_back(cyc + 1 + 16);
        @(negedge clk);
        start16 = 1'b0;
    endtask

    function automatic int qsize(input int w);
        case (w)
            8:       return q8.size();
            1:       return q1.size();
            default: return q16.size();
        endcase
    endfunction

    task automatic drain(input int w);
        for (int i = 0; i < 100; i++) begin
            if (qsize(w) == 0) break;
            @(negedge clk);
            #1;
        end
        check($sformatf("drain_n%0d", w), qsize(w), 0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] vec_a[3] = '{8'd5, 8'd0, 8'hFF};
    logic [7:0] vec_b[3] = '{8'd9, 8'd0, 8'hFF};
    logic [8:0] vec_e[3] = '{9'h1FC, 9'h000, 9'h000};
    logic [1:0] n1_e[4]  = '{2'b00, 2'b11, 2'b01, 2'b00};

    initial begin
        int nb;

        // Reset held two cycles with start high on every instance.
        rst = 1'b1;
        start8 = 1'b1; start1 = 1'b1; start16 = 1'b1;
        a8 = 8'd77; b8 = 8'd3; a1 = 1'b1; a16 = 16'h1234; b16 = 16'h0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_d8", d8, 0);
        check("rst_bout8", bout8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_state8", st8, OCIOSO);
        check("rst_busy1", busy1, 0);
        check("rst_d16", d16, 0);
        check("rst_busy16", busy16, 0);
        rst = 1'b0;
        start8 = 1'b0; start1 = 1'b0; start16 = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy8", busy8, 0);
        check("idle_state8", st8, OCIOSO);

        // Basic: 100 - 37, busy counted until done.
        go8(8'd100, 8'd37, 9'h03F);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) break;
            if (busy8) nb++;
            @(negedge clk);
        end
        check("busy_cycles", nb, 8);
        drain(8);

        // Borrow and edge operands.
        for (int i = 0; i < 3; i++) begin
            go8(vec_a[i], vec_b[i], vec_e[i]);
            drain(8);
        end

        // start during CALCULA is ignored.
        go8(8'd20, 8'd3, 9'd17);
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain(8);

        // start held through FIM gives back-to-back results.
        @(negedge clk);
        a8 = 8'd0; b8 = 8'd1; start8 = 1'b1;
        q8.push_back(9'h1FF); c8.push_back(cyc + 1 + 8);
        q8.push_back(9'h1FF); c8.push_back(cyc + 1 + 8 + 9);
        repeat (10) @(negedge clk);
        start8 = 1'b0;
        drain(8);

        // Reset mid-operation abandons the computation.
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_d8", d8, 0);
        check("midrst_bout8", bout8, 0);
        check("midrst_busy8", busy8, 0);
        check("midrst_state8", st8, OCIOSO);
        repeat (12) @(negedge clk);
        go8(8'd10, 8'd10, 9'h000);
        drain(8);

        // N = 1: all four operand pairs.
        for (int i = 0; i < 4; i++) begin
            go1(i[1], i[0], n1_e[i]);
            drain(1);
        end

        // N = 16: random pairs plus the extremes.
        go16(16'h0000, 16'hFFFF);
        drain(16);
        go16(16'hFFFF, 16'h0000);
        drain(16);
        for (int i = 0; i < 200; i++) begin
            go16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            drain(16);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
